mc_controller: RTL and testbench

//   Multicycle control unit for the ARM-subset core: one shared ALU and one unified memory

---
 rtl/mc_controller_if.sv | 31 +++
 rtl/mc_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the ARM-subset datapath (slave).
interface mc_controller_if #(
    parameter int STATE_W = 4
);
    logic [19:0]        Instr;
    logic [3:0]         ALUFlags;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUControl;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [STATE_W-1:0] State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decode, NZCV flags and conditional execution.
// Optional CMP_TST_EN adds CMP/TST (flag-only ops that skip the ALUWB state).
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] flags_reg;
    logic       cond_ex_d_reg;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       s_or_l;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign cmd       = funct[4:1];
    assign s_or_l    = funct[0];
    assign unused_rn = ^bus.Instr[7:4];

    // ALU command decode; unsupported commands leave cmd_ok low so no state is written
    logic [1:0] alu_ctl_dec;
    logic       cmd_ok;
    logic       add_sub;
    logic       no_write;

    always_comb begin
        alu_ctl_dec = 2'b00;
        cmd_ok      = 1'b0;
        add_sub     = 1'b0;
        no_write    = 1'b0;
        case (cmd)
            4'b0100: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b00; add_sub = 1'b1; end
            4'b0010: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b01; add_sub = 1'b1; end
            4'b0000: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b10; end
            4'b1100: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b11; end
`ifdef CMP_TST_EN
            4'b1010: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b01; add_sub = 1'b1; no_write = 1'b1; end
            4'b1000: begin cmd_ok = 1'b1; alu_ctl_dec = 2'b10; no_write = 1'b1; end
`endif
            default: ;
        endcase
    end

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = ~cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cf & ~z;
            4'b1001: cond_eval = ~cf | z;
            4'b1010: cond_eval = ~(n ^ v);
            4'b1011: cond_eval = n ^ v;
            4'b1100: cond_eval = ~z & ~(n ^ v);
            4'b1101: cond_eval = z | (n ^ v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Evaluate all 16 codes against the stored flags, then select by the instruction's cond field
    logic [15:0] cond_table;
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cond
            assign cond_table[gi] = cond_eval(4'(gi), flags_reg);
        end
    endgenerate

    logic cond_ex;
    assign cond_ex = cond_table[cond];

    logic       ir_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control, flag_w;
    logic       reg_w, mem_w, branch;

    always_comb begin
        state_next  = state_reg;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        flag_w      = 2'b00;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        case (state_reg)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
                state_next = s_or_l ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src    = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                state_next = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_b   = (state_reg == EXECI) ? 2'b01 : 2'b00;
                alu_control = alu_ctl_dec;
                flag_w      = (cmd_ok & s_or_l) ? {1'b1, add_sub} : 2'b00;
                state_next  = no_write ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_w      = cmd_ok;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Flag writes use the pre-update CondEx; later writes use the value registered one cycle earlier
    logic [1:0] flag_write;
    logic       pcs;
    assign flag_write = flag_w & {2{cond_ex}};
    assign pcs        = branch | (reg_w & (rd == 4'hF));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= FETCH;
            flags_reg     <= 4'b0000;
            cond_ex_d_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cond_ex_d_reg <= cond_ex;
            if (flag_write[1]) flags_reg[3:2] <= bus.ALUFlags[3:2];
            if (flag_write[0]) flags_reg[1:0] <= bus.ALUFlags[1:0];
        end
    end

    assign bus.PCWrite    = (state_reg == FETCH) | (pcs & cond_ex_d_reg);
    assign bus.RegWrite   = reg_w & cond_ex_d_reg;
    assign bus.MemWrite   = mem_w & cond_ex_d_reg;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {(op == 2'b01) & ~s_or_l, op == 2'b10};
    assign bus.State      = STATE_W'(state_reg);
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level model pushes per-cycle expectations.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_controller_if #(.STATE_W(4)) bus();
    mc_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;
    exp_t sb_q[$];

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] tb_flags = 4'b0000;

    logic [15:0] ctl_obs;
    assign ctl_obs = {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
                      bus.ImmSrc, bus.RegSrc};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic logic [15:0] exp_ctl(input int st, input logic [1:0] op, input logic l,
                                            input logic [3:0] rd, input logic pass,
                                            input logic ok, input logic [1:0] alu);
        logic irw, pcw, rw, mw, adr, a;
        logic [1:0] b, res, aluc, rs;
        {irw, pcw, rw, mw, adr, a} = 6'b0;
        b = 2'b00; res = 2'b00; aluc = 2'b00;
        rs = {op == 2'b01 && !l, op == 2'b10};
        case (st)
            0: begin irw = 1; pcw = 1; a = 1; b = 2'b10; res = 2'b10; end
            1: begin a = 1; b = 2'b10; res = 2'b10; end
            2: b = 2'b01;
            3: adr = 1;
            4: begin res = 2'b01; rw = pass; pcw = pass && rd == 4'hF; end
            5: begin adr = 1; mw = pass; end
            6, 7: begin b = (st == 7) ? 2'b01 : 2'b00; aluc = ok ? alu : 2'b00; end
            8: begin rw = pass && ok; pcw = pass && ok && rd == 4'hF; end
            9: begin b = 2'b01; res = 2'b10; pcw = pass; end
            default: ;
        endcase
        return {irw, pcw, rw, mw, adr, a, b, res, aluc, op, rs};
    endfunction

    task automatic push_instr(input logic [19:0] ins, input logic [3:0] af, output int ncyc);
        logic [3:0] c, cmd, rd;
        logic [1:0] op, alu;
        logic [5:0] funct;
        logic pass, ok, as, nw;
        int sts[$];
        exp_t e;
        c = ins[19:16]; op = ins[15:14]; funct = ins[13:8]; rd = ins[3:0];
        cmd = funct[4:1];
        pass = cond_ok(c, tb_flags);
        ok = 0; alu = 2'b00; as = 0; nw = 0;
        case (cmd)
            4'b0100: begin ok = 1; alu = 2'd0; as = 1; end
            4'b0010: begin ok = 1; alu = 2'd1; as = 1; end
            4'b0000: begin ok = 1; alu = 2'd2; end
            4'b1100: begin ok = 1; alu = 2'd3; end
`ifdef CMP_TST_EN
            4'b1010: begin ok = 1; alu = 2'd1; as = 1; nw = 1; end
            4'b1000: begin ok = 1; alu = 2'd2; nw = 1; end
`endif
            default: ;
        endcase
        sts.push_back(0);
        sts.push_back(1);
        case (op)
            2'b01: begin
                sts.push_back(2);
                if (funct[0]) begin sts.push_back(3); sts.push_back(4); end
                else sts.push_back(5);
            end
            2'b00: begin
                sts.push_back(funct[5] ? 7 : 6);
                if (!(ok && nw)) sts.push_back(8);
            end
            2'b10: sts.push_back(9);
            default: ;
        endcase
        foreach (sts[i]) begin
            e.st  = 4'(sts[i]);
            e.ctl = exp_ctl(sts[i], op, funct[0], rd, pass, ok, alu);
            sb_q.push_back(e);
        end
        if (op == 2'b00 && pass && ok && funct[0]) begin
            tb_flags[3:2] = af[3:2];
            if (as) tb_flags[1:0] = af[1:0];
        end
        ncyc = sts.size();
    endtask

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {c, op, funct, 4'h0, rd};
    endfunction

    task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] af);
        int n;
        bus.Instr    = ins;
        bus.ALUFlags = af;
        push_instr(ins, af, n);
        $display("instr %-8s ins=0x%05h alu_flags=%b cycles=%0d model_flags=%b",
                 name, ins, af, n, tb_flags);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state", 32'(bus.State), 32'(e.st));
            chk("ctl", 32'(ctl_obs), 32'(e.ctl));
        end
    end

    localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000, NE = 4'b0001, NV = 4'b1111;

    initial begin
        logic [19:0] ins;
        int n;
        bus.Instr    = 20'h0;
        bus.ALUFlags = 4'h0;
        #1;
        chk("rst_state", 32'(bus.State), 32'd0);
        chk("rst_irw",   32'(bus.IRWrite), 32'd1);
        chk("rst_pcw",   32'(bus.PCWrite), 32'd1);
        chk("rst_srca",  32'(bus.ALUSrcA), 32'd1);
        chk("rst_srcb",  32'(bus.ALUSrcB), 32'd2);
        chk("rst_res",   32'(bus.ResultSrc), 32'd2);
        chk("rst_aluc",  32'(bus.ALUControl), 32'd0);
        chk("rst_adr",   32'(bus.AdrSrc), 32'd0);
        chk("rst_regw",  32'(bus.RegWrite), 32'd0);
        chk("rst_memw",  32'(bus.MemWrite), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_state", 32'(bus.State), 32'd0);
        reset = 1'b0;

        run_instr("ADDS",   mk(AL, 2'b00, 6'b101001, 4'd1), 4'b0110);
        run_instr("ADDEQ",  mk(EQ, 2'b00, 6'b101000, 4'd1), 4'b0000);
        run_instr("LDR",    mk(AL, 2'b01, 6'b011001, 4'd2), 4'b0000);
        run_instr("STRNE",  mk(NE, 2'b01, 6'b011000, 4'd2), 4'b0000);
        run_instr("ADDS0",  mk(AL, 2'b00, 6'b101001, 4'd1), 4'b0000);
        run_instr("STRNE",  mk(NE, 2'b01, 6'b011000, 4'd2), 4'b0000);
        run_instr("B",      mk(AL, 2'b10, 6'b101111, 4'hF), 4'b0000);
        run_instr("CMP",    mk(AL, 2'b00, 6'b110101, 4'd0), 4'b0110);
        run_instr("ADDEQ",  mk(EQ, 2'b00, 6'b101000, 4'd4), 4'b0000);
        run_instr("EORS",   mk(AL, 2'b00, 6'b000011, 4'd5), 4'b1001);
        run_instr("ADDNE",  mk(NE, 2'b00, 6'b101000, 4'd5), 4'b0000);
        run_instr("ADDPC",  mk(AL, 2'b00, 6'b001000, 4'hF), 4'b0000);
        run_instr("ADDSNV", mk(NV, 2'b00, 6'b101001, 4'd6), 4'b1111);
        run_instr("NOP",    mk(AL, 2'b11, 6'b000000, 4'd0), 4'b0000);
        run_instr("ORRS",   mk(AL, 2'b00, 6'b011001, 4'd7), 4'b1010);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] cmds [7];
            logic [1:0] rop;
            logic [5:0] f;
            cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1000, 4'b0001};
            rop = 2'($urandom_range(0, 3));
            case (rop)
                2'b00:   f = {1'($urandom), cmds[$urandom_range(0, 6)], 1'($urandom)};
                2'b01:   f = {5'b01100, 1'($urandom)};
                default: f = {2'b10, 4'($urandom)};
            endcase
            run_instr("RAND", mk(4'($urandom), rop, f, 4'($urandom)), 4'($urandom));
        end

        // Reset asserted in the middle of MEMRD discards the load
        run_instr("ADDSZ", mk(AL, 2'b00, 6'b101001, 4'd1), 4'b0100);
        ins = mk(AL, 2'b01, 6'b011001, 4'd2);
        bus.Instr = ins;
        push_instr(ins, 4'b0000, n);
        $display("instr %-8s ins=0x%05h reset asserted mid-MEMRD", "LDR", ins);
        repeat (3) @(posedge clk);
        #1;
        sb_q.delete();
        chk("pre_rst_state", 32'(bus.State), 32'd3);
        chk("pre_rst_adr",   32'(bus.AdrSrc), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(bus.State), 32'd0);
        chk("mid_rst_regw",  32'(bus.RegWrite), 32'd0);
        chk("mid_rst_memw",  32'(bus.MemWrite), 32'd0);
        chk("mid_rst_irw",   32'(bus.IRWrite), 32'd1);
        tb_flags = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("ADDNE",  mk(NE, 2'b00, 6'b101000, 4'd3), 4'b0000);
        run_instr("ADDEQ",  mk(EQ, 2'b00, 6'b101000, 4'd3), 4'b0000);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
